// File: rtl/pr_timer_dev.sv
// Processor-bus programmable down-counting timer: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload operation and a level-sensitive maskable interrupt.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for EN; COUNT holds its last value
// LOAD  | copy PRESET into COUNT
// CNT   | decrement COUNT each cycle until it reaches zero or EN drops
// INT   | raise PEND; reload (auto-reload) or clear EN and stop (one-shot)
module pr_timer_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] PrAddr,
    input  logic [31:0] PrWD,
    input  logic [3:0]  PrBE,
    input  logic        IOWrite,
    output logic [31:0] PrRD,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    state_t      state;
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic        pend;
    logic [31:0] preset;
    logic [31:0] count;

    logic        hit;
    logic [1:0]  offset;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        freeze;
    logic        auto_reload;

    logic        en_nxt;
    logic [1:0]  mode_nxt;
    logic        im_nxt;
    logic        pend_nxt;

    assign hit         = (PrAddr[31:4] == BASE_ADDR[31:4]);
    assign offset      = PrAddr[3:2];
    assign wr_ctrl     = IOWrite && hit && (offset == OFF_CTRL) && PrBE[0];
    assign wr_preset   = IOWrite && hit && (offset == OFF_PRESET);
    assign auto_reload = (mode == 2'b01);

    // A store that clears EN stops the count on that same edge, so the value
    // software just read is the value that stays frozen.
    assign freeze      = wr_ctrl && !PrWD[0];

    // Control-field next values: the FSM's INT actions first, then the CPU
    // store overrides EN and always clears PEND.
    always_comb begin
        en_nxt   = en;
        mode_nxt = mode;
        im_nxt   = im;
        pend_nxt = pend;
        if (state == S_INT) begin
            pend_nxt = 1'b1;
            if (!auto_reload) begin
                en_nxt = 1'b0;
            end
        end
        if (wr_ctrl) begin
            en_nxt   = PrWD[0];
            mode_nxt = PrWD[2:1];
            im_nxt   = PrWD[3];
            pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            en     <= 1'b0;
            mode   <= 2'b00;
            im     <= 1'b0;
            pend   <= 1'b0;
            preset <= 32'h0;
            count  <= 32'h0;
            IRQ    <= 1'b0;
        end else begin
            en   <= en_nxt;
            mode <= mode_nxt;
            im   <= im_nxt;
            pend <= pend_nxt;
            IRQ  <= im_nxt && pend_nxt;

            for (int i = 0; i < 4; i++) begin
                if (wr_preset && PrBE[i]) begin
                    preset[8*i +: 8] <= PrWD[8*i +: 8];
                end
            end

            case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (count == 32'h0) begin
                        state <= S_INT;
                    end else if (!freeze) begin
                        count <= count - 32'd1;
                    end
                end
                S_INT: begin
                    state <= auto_reload ? S_LOAD : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        PrRD = 32'h0;
        if (hit) begin
            case (offset)
                OFF_CTRL:   PrRD = {27'h0, pend, im, mode, en};
                OFF_PRESET: PrRD = preset;
                OFF_COUNT:  PrRD = count;
                default:    PrRD = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_pr_timer_dev.sv
// Directed bench for pr_timer_dev: stimulus pushes expected read/IRQ values into
// a queue, an independent monitor pops and compares whenever a read is presented.
module tb_pr_timer_dev;

    localparam logic [31:0] BASE     = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = BASE + 32'd0;
    localparam logic [31:0] A_PRESET = BASE + 32'd4;
    localparam logic [31:0] A_COUNT  = BASE + 32'd8;
    localparam logic [31:0] A_RSVD   = BASE + 32'd12;
    localparam logic [31:0] A_OUT0   = BASE + 32'd16;
    localparam logic [31:0] A_OUT1   = BASE + 32'd20;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:2] PrAddr = '0;
    logic [31:0] PrWD = '0;
    logic [3:0]  PrBE = '0;
    logic        IOWrite = 1'b0;
    logic [31:0] PrRD;
    logic        IRQ;

    logic        rd_valid = 1'b0;
    exp_t        sbq[$];
    exp_t        mon_x;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pr_timer_dev #(.BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .rst     (rst),
        .PrAddr  (PrAddr),
        .PrWD    (PrWD),
        .PrBE    (PrBE),
        .IOWrite (IOWrite),
        .PrRD    (PrRD),
        .IRQ     (IRQ)
    );

    // Monitor: a read is presented while rd_valid is high; sample at negedge.
    always @(negedge clk) begin
        if (rd_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: read presented with no expected entry");
            end else begin
                mon_x = sbq.pop_front();
                if (PrRD !== mon_x.rd || IRQ !== mon_x.irq) begin
                    errors++;
                    $display("FAIL %s: got PrRD=%h IRQ=%b, want PrRD=%h IRQ=%b",
                             mon_x.name, PrRD, IRQ, mon_x.rd, mon_x.irq);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One store; returns 1ns after the edge at which it takes effect.
    task automatic wr(input logic [31:0] baddr, input logic [31:0] d, input logic [3:0] be);
        PrAddr  = baddr[31:2];
        PrWD    = d;
        PrBE    = be;
        IOWrite = 1'b1;
        @(posedge clk);
        #1;
        IOWrite = 1'b0;
        PrBE    = 4'h0;
    endtask

    // Present a read in the current cycle; consumes no rising edge when
    // called just after one.
    task automatic chk(input logic [31:0] baddr, input logic [31:0] e,
                       input logic ei, input string nm);
        exp_t x;
        x.name = nm;
        x.rd   = e;
        x.irq  = ei;
        PrAddr = baddr[31:2];
        sbq.push_back(x);
        rd_valid = 1'b1;
        @(negedge clk);
        #1;
        rd_valid = 1'b0;
    endtask

    initial begin
        // Reset and window decode
        tick(3);
        rst = 1'b1;
        tick(1);
        chk(A_CTRL,   32'h0, 1'b0, "rst_ctrl");   tick(1);
        chk(A_PRESET, 32'h0, 1'b0, "rst_preset"); tick(1);
        chk(A_COUNT,  32'h0, 1'b0, "rst_count");  tick(1);
        chk(A_RSVD,   32'h0, 1'b0, "rst_rsvd");
        wr(A_OUT0, 32'hFFFF_FFFF, 4'hF);
        wr(A_OUT1, 32'hFFFF_FFFF, 4'hF);
        chk(A_CTRL,   32'h0, 1'b0, "outside_ctrl");   tick(1);
        chk(A_PRESET, 32'h0, 1'b0, "outside_preset"); tick(3);
        chk(A_COUNT,  32'h0, 1'b0, "outside_count");

        // One-shot, PRESET=5, IM: IRQ at E9
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);            // E0
        tick(2);
        chk(A_COUNT, 32'd5, 1'b0, "os_count_load");
        tick(6);                            // E8
        chk(A_CTRL, 32'h09, 1'b0, "os_e8_no_irq");
        tick(1);                            // E9
        chk(A_CTRL, 32'h18, 1'b1, "os_e9_irq");
        tick(1);
        chk(A_COUNT, 32'd0, 1'b1, "os_count_zero");
        tick(1);
        chk(A_OUT0, 32'h0, 1'b1, "os_outside_read");
        wr(A_CTRL, 32'h0, 4'h1);
        chk(A_CTRL, 32'h0, 1'b0, "os_clear");

        // Auto-reload, PRESET=3: PEND at E7, then every 6 edges
        wr(A_PRESET, 32'd3, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);            // E0
        tick(6);
        chk(A_CTRL, 32'h0B, 1'b0, "ar_e6");
        tick(1);                            // E7
        chk(A_CTRL, 32'h1B, 1'b1, "ar_e7_pend");
        wr(A_CTRL, 32'hB, 4'h1);            // E8 clears PEND
        chk(A_CTRL, 32'h0B, 1'b0, "ar_cleared");
        tick(4);                            // E12
        chk(A_CTRL, 32'h0B, 1'b0, "ar_e12");
        tick(1);                            // E13
        chk(A_CTRL, 32'h1B, 1'b1, "ar_e13_pend");
        wr(A_CTRL, 32'h0, 4'h1);
        tick(3);

        // CTRL write coinciding with the INT edge: PEND stays clear
        wr(A_PRESET, 32'd0, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);            // E0
        tick(3);
        wr(A_CTRL, 32'hB, 4'h1);            // E4 (FSM in INT)
        chk(A_CTRL, 32'h0B, 1'b0, "col_pend_clear");
        tick(2);                            // E6
        chk(A_CTRL, 32'h0B, 1'b0, "col_e6");
        tick(1);                            // E7
        chk(A_CTRL, 32'h1B, 1'b1, "col_e7_pend");
        wr(A_CTRL, 32'h0, 4'h1);
        tick(3);

        // Freeze at 50 and reload on re-enable
        wr(A_PRESET, 32'd100, 4'hF);
        wr(A_CTRL, 32'h1, 4'h1);            // E0
        tick(52);
        chk(A_COUNT, 32'd50, 1'b0, "frz_at_50");
        wr(A_CTRL, 32'h0, 4'h1);
        chk(A_COUNT, 32'd50, 1'b0, "frz_write_edge");
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk(A_COUNT, 32'd50, 1'b0, "frz_hold");
        end
        tick(1);
        chk(A_CTRL, 32'h0, 1'b0, "frz_ctrl");
        wr(A_CTRL, 32'h1, 4'h1);            // E0
        tick(2);
        chk(A_COUNT, 32'd100, 1'b0, "frz_reload");
        tick(1);
        chk(A_COUNT, 32'd99, 1'b0, "frz_dec_after_reload");
        wr(A_CTRL, 32'h0, 4'h1);
        tick(3);
        chk(A_COUNT, 32'd99, 1'b0, "frz_stop_99");

        // Byte enables, read-only and reserved offsets
        wr(A_PRESET, 32'h0, 4'hF);
        wr(A_PRESET, 32'hAABB_CCDD, 4'b0010);
        chk(A_PRESET, 32'h0000_CC00, 1'b0, "be_byte1");
        wr(A_PRESET, 32'hAABB_CCDD, 4'b1001);
        chk(A_PRESET, 32'hAA00_CCDD, 1'b0, "be_byte0_3");
        wr(A_CTRL, 32'h8, 4'h1);
        chk(A_CTRL, 32'h08, 1'b0, "ctrl_im_only");
        wr(A_CTRL, 32'hF, 4'b1110);
        chk(A_CTRL, 32'h08, 1'b0, "ctrl_be0_low");
        wr(A_COUNT, 32'h1234_5678, 4'hF);
        chk(A_COUNT, 32'd99, 1'b0, "count_ro");
        wr(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        chk(A_RSVD, 32'h0, 1'b0, "rsvd_ro");

        // Pending with IM=0
        wr(A_PRESET, 32'd0, 4'hF);
        wr(A_CTRL, 32'h1, 4'h1);            // E0
        tick(4);
        chk(A_CTRL, 32'h10, 1'b0, "im0_pend");
        tick(1);
        chk(A_COUNT, 32'd0, 1'b0, "im0_count");
        wr(A_CTRL, 32'h8, 4'h1);
        chk(A_CTRL, 32'h08, 1'b0, "im1_pend_cleared");
        tick(1);
        chk(A_CTRL, 32'h08, 1'b0, "im1_irq_stays_low");

        // Reset while counting with IRQ high
        wr(A_PRESET, 32'd2, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);            // E0
        tick(6);
        chk(A_CTRL, 32'h1B, 1'b1, "mid_pend");
        tick(2);
        chk(A_COUNT, 32'd1, 1'b1, "mid_count");
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk(A_CTRL, 32'h0, 1'b0, "mid_rst_ctrl");    tick(1);
        chk(A_PRESET, 32'h0, 1'b0, "mid_rst_preset"); tick(1);
        chk(A_COUNT, 32'h0, 1'b0, "mid_rst_count");
        tick(2);

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover: %0d entries, want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pr_timer_dev.md
# pr_timer_dev

Programmable down-counting timer that sits on the processor-bus (Pr*) side of the system, answering the load/store accesses the `mips` core issues through `PrAddr`/`PrWD`/`PrBE`/`IOWrite`/`PrRD`. It is the device end of that bus. Its interrupt output feeds one bit of the core's `HWInt[7:2]` input. It provides one-shot and auto-reload modes, a maskable interrupt and a readable live count.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00: word-aligned base address. Bits [3:0] are ignored; the block decodes a 16-byte window.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `PrAddr`  in  30  word address [31:2] from the core.
- `PrWD`  in  32  write data.
- `PrBE`  in  4  byte enables for writes; bit i qualifies `PrWD[8i+7:8i]`.
- `IOWrite`  in  1  write strobe, valid for one cycle per store.
- `PrRD`  out  32  read data, combinational from address and registers.
- `IRQ`  out  1  interrupt request, registered, level-sensitive. The top level wires it to `HWInt[2]`.

## Operation
- Hit: `PrAddr[31:4] == BASE_ADDR[31:4]`. Offset is `PrAddr[3:2]`.
  - 0 = CTRL (R/W)
  - 1 = PRESET (R/W)
  - 2 = COUNT (R only; writes ignored)
  - 3 = reserved (reads 0, writes ignored)
- CTRL layout:
  - bit0 EN
  - bits[2:1] MODE: 00 one-shot, 01 auto-reload; 10 and 11 behave as 00
  - bit3 IM (interrupt enable)
  - bit4 PEND (read-only)
  - all other bits read 0
- CTRL writes: only bits [3:0], and only when `PrBE[0]`=1. Any CTRL write with `PrBE[0]`=1 clears PEND.
- PRESET writes are byte-wise per `PrBE`.
- PrRD: selected register when hit, else 32'h0. Reads have no side effects.
- FSM states:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - if EN=0, go to IDLE (COUNT holds);
    - else if COUNT==0, go to INT;
    - else COUNT <= COUNT-1.
  - INT: PEND <= 1.
    - one-shot: EN <= 0, go to IDLE.
    - auto-reload: go to LOAD.
- `IRQ` is registered: IRQ <= IM & PEND (next-state values). It therefore falls in the same cycle PEND clears.
- COUNT arithmetic is 32-bit unsigned. A decrement never occurs at 0, so there is no wrap-around.

## Timing
- Reset (`rst`=0 at an edge): CTRL=0, PRESET=0, COUNT=0, PEND=0, state=IDLE, IRQ=0. PrRD then reads 0 for every offset.
- A write takes effect at the edge where `IOWrite`=1. The new value is visible on PrRD the following cycle.
- Latency, with E0 as the write edge setting EN and PRESET=N already loaded:
  - E1: enters LOAD.
  - E2: COUNT=N, enters CNT.
  - E(N+3): enters INT.
  - E(N+4): PEND=1 and IRQ=1 (if IM=1).
  - Total: N+4 edges from E0 to IRQ.
- Auto-reload period: N+3 cycles between successive PEND-setting edges. PEND stays set until software clears it.
- PRESET=0: the count completes immediately; IRQ is set 4 edges after the enable write.
- A PRESET write during CNT does not alter COUNT until the next LOAD.
- An EN=0 write during CNT freezes COUNT and returns to IDLE at the next edge. Re-enabling reloads from PRESET.
- Simultaneous CPU CTRL write and FSM update in the same edge: the CPU write wins for EN. PEND clears if written, even if the FSM is in INT that edge.
- Reset mid-count: everything returns to reset values at that edge and IRQ drops.

## Test plan
- Reset, then read offsets 0/1/2/3 -> all 32'h0; IRQ=0. Write an address outside the window -> no register changes.
- PRESET=5, CTRL=4'b1001 (one-shot, IM, EN) -> IRQ rises exactly 9 edges after the CTRL write. CTRL then reads 5'b1_1000 (EN cleared, PEND set), and COUNT reads 0.
- Auto-reload, PRESET=3, CTRL=4'b1011 -> PEND sets at +7 edges after the CTRL write. After a CTRL write of 4'b1011 clears PEND, the next set occurs 6 edges after the previous one.
- PRESET=100 counting: write CTRL.EN=0 when COUNT reads 50 -> COUNT holds at 50 for 10 cycles. Re-enable -> COUNT reloads 100.
- PrBE=4'b0010, PrWD=32'hAABBCCDD to PRESET (initially 0) -> PRESET reads 32'h0000CC00. A CTRL write with PrBE[0]=0 -> CTRL unchanged.
- Interrupt pending with IM=0 -> IRQ=0 while PEND=1. Write CTRL IM=1 without a PEND clear is impossible (every CTRL write clears PEND) -> verify IRQ stays 0. Assert `rst`=0 mid-count -> all state and IRQ equal 0 at the next edge.
